axis_capture_sink: RTL and testbench

AXI-Stream slave sink that terminates a 32-bit stream such as the m03 output of `main_wrapper`. It captures accepted beats into an internal word memory and tracks packet boundaries, packet length and strobe errors. Captured data can be read back through a registered read port. It is the receiving end of the wrapper's master stream, used on-chip as a loopback and capture target and in benches as the checked consumer.

---
 rtl/axis_capture_sink.sv | 146 ++++++++++++++
 tb/tb_axis_capture_sink.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_capture_sink.sv
// AXI-Stream capture sink: stores accepted beats in a word memory, tracks packet
// boundaries, lengths and strobe/truncation errors, and offers a 1-cycle readback port.
module axis_capture_sink #(
  parameter int MEM_SIZE   = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    s00_axis_aclk,
  input  logic                    s00_axis_areset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [ADDR_WIDTH-1:0]   word_count,
  output logic [15:0]             pkt_count,
  output logic [ADDR_WIDTH-1:0]   last_pkt_len,
  output logic                    pkt_done,
  output logic                    full,
  output logic                    strb_err,
  output logic                    trunc
);

  localparam int                    IDX_W   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_LIM = ADDR_WIDTH'(MEM_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FULL} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_SIZE];
  logic [ADDR_WIDTH-1:0]   r_word_count;
  logic [ADDR_WIDTH-1:0]   r_cur_len;
  logic [ADDR_WIDTH-1:0]   r_last_pkt_len;
  logic [15:0]             r_pkt_count;
  logic                    r_in_pkt;
  logic                    r_pkt_done;
  logic                    r_strb_err;
  logic                    r_trunc;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid;

  logic                    w_tready;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_wc_inc;
  logic                    w_fill;
  logic                    w_open_nxt;
  logic                    w_strb_full;

  assign w_tready    = (r_state == S_CAPTURE) & ~clear;
  assign w_accept    = s00_axis_tvalid & w_tready;
  assign w_wc_inc    = r_word_count + ADDR_WIDTH'(1);
  assign w_fill      = w_accept & (w_wc_inc == MEM_LIM);
  // Packet state after this cycle; decides whether a disabled sink may go idle.
  assign w_open_nxt  = w_accept ? ~s00_axis_tlast : r_in_pkt;
  assign w_strb_full = &s00_axis_tstrb;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (enable) w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (w_fill)                       w_state_nxt = S_FULL;
        else if (!enable && !w_open_nxt)  w_state_nxt = S_IDLE;
      end
      S_FULL:    w_state_nxt = S_FULL;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_state        <= S_IDLE;
      r_word_count   <= '0;
      r_cur_len      <= '0;
      r_last_pkt_len <= '0;
      r_pkt_count    <= '0;
      r_in_pkt       <= 1'b0;
      r_pkt_done     <= 1'b0;
      r_strb_err     <= 1'b0;
      r_trunc        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pkt_done <= 1'b0;
      if (clear) begin
        r_word_count   <= '0;
        r_cur_len      <= '0;
        r_last_pkt_len <= '0;
        r_pkt_count    <= '0;
        r_in_pkt       <= 1'b0;
        r_strb_err     <= 1'b0;
        r_trunc        <= 1'b0;
      end else if (w_accept) begin
        r_word_count <= w_wc_inc;
        r_in_pkt     <= ~s00_axis_tlast;
        if (s00_axis_tlast) begin
          r_last_pkt_len <= r_cur_len + ADDR_WIDTH'(1);
          r_cur_len      <= '0;
          r_pkt_done     <= 1'b1;
          if (r_pkt_count != 16'hFFFF) r_pkt_count <= r_pkt_count + 16'd1;
        end else begin
          // Partial strobes are only legal on the closing beat.
          r_cur_len <= r_cur_len + ADDR_WIDTH'(1);
          if (!w_strb_full) r_strb_err <= 1'b1;
          if (w_fill)       r_trunc    <= 1'b1;
        end
      end
    end
  end

  // Capture memory is never reset so contents survive clear and reset.
  always_ff @(posedge s00_axis_aclk) begin
    if (w_accept && !s00_axis_areset)
      r_mem[r_word_count[IDX_W-1:0]] <= s00_axis_tdata;
  end

  // Read samples the pre-write contents, so a same-address collision returns old data.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en)
        r_rd_data <= (rd_addr < MEM_LIM) ? r_mem[rd_addr[IDX_W-1:0]] : '0;
    end
  end

  assign s00_axis_tready = w_tready;
  assign rd_data         = r_rd_data;
  assign rd_valid        = r_rd_valid;
  assign word_count      = r_word_count;
  assign pkt_count       = r_pkt_count;
  assign last_pkt_len    = r_last_pkt_len;
  assign pkt_done        = r_pkt_done;
  assign full            = (r_state == S_FULL);
  assign strb_err        = r_strb_err;
  assign trunc           = r_trunc;

endmodule

// File: tb/tb_axis_capture_sink.sv
// Scoreboard bench for axis_capture_sink: stimulus pushes expected readback and
// packet-completion records; a negedge monitor pops them when the DUT presents them.
module tb_axis_capture_sink;

  logic        clk = 1'b0;
  logic        areset, enable, clear;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tvalid, tlast, tready;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [11:0] word_count, last_pkt_len;
  logic [15:0] pkt_count;
  logic        pkt_done, full, strb_err, trunc;

  always #5 clk = ~clk;

  axis_capture_sink #(.MEM_SIZE(64), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(areset), .enable(enable), .clear(clear),
    .s00_axis_tdata(tdata), .s00_axis_tstrb(tstrb), .s00_axis_tvalid(tvalid),
    .s00_axis_tlast(tlast), .s00_axis_tready(tready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .word_count(word_count), .pkt_count(pkt_count),
    .last_pkt_len(last_pkt_len), .pkt_done(pkt_done), .full(full), .strb_err(strb_err),
    .trunc(trunc));

  int total = 0, bad = 0;
  logic [31:0] rd_q [$];
  logic [27:0] pkt_q [$];   // {pkt_count, last_pkt_len}
  logic [31:0] mm [64];
  int mword = 0, mcur = 0, mpkt = 0, gdat = 32'h100;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) chk("rd_spurious", 32'(rd_q.size()), 32'd1);
      else                  chk("rd_data", rd_data, rd_q.pop_front());
    end
    if (pkt_done === 1'b1) begin
      if (pkt_q.size() == 0) chk("pkt_done_spurious", 32'(pkt_q.size()), 32'd1);
      else begin
        logic [27:0] e;
        e = pkt_q.pop_front();
        chk("pkt_count_at_done", 32'(pkt_count), 32'(e[27:12]));
        chk("last_pkt_len_at_done", 32'(last_pkt_len), 32'(e[11:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    mword = 0; mcur = 0; mpkt = 0;
  endtask

  task automatic chk_stat(input string n, input int wc, input int pc, input int pl,
                          input bit f, input bit se, input bit tr);
    @(negedge clk);
    chk({n, "_word_count"}, 32'(word_count), 32'(wc));
    chk({n, "_pkt_count"}, 32'(pkt_count), 32'(pc));
    chk({n, "_last_pkt_len"}, 32'(last_pkt_len), 32'(pl));
    chk({n, "_full"}, 32'(full), 32'(f));
    chk({n, "_strb_err"}, 32'(strb_err), 32'(se));
    chk({n, "_trunc"}, 32'(trunc), 32'(tr));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string n);
    @(negedge clk);
    chk({n, "_tready"}, 32'(tready), 32'd0);
    chk({n, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({n, "_rd_data"}, rd_data, 32'd0);
    chk({n, "_pkt_done"}, 32'(pkt_done), 32'd0);
    @(posedge clk); #1;
    chk_stat(n, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Presents one beat for up to 4 cycles; checks acceptance and updates the model.
  task automatic beat(input logic [31:0] d, input bit l, input logic [3:0] s, input bit exp_acc);
    bit acc;
    acc = 1'b0;
    tvalid = 1'b1; tdata = d; tlast = l; tstrb = s;
    for (int k = 0; k < 4 && !acc; k++) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk); #1;
      rd_en = 1'b0;
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("beat_accept", 32'(acc), 32'(exp_acc));
    if (acc) begin
      if (mword < 64) mm[mword] = d;
      mword++; mcur++;
      if (l) begin
        if (mpkt < 65535) mpkt++;
        pkt_q.push_back({16'(mpkt), 12'(mcur)});
        mcur = 0;
      end
    end
  endtask

  task automatic send_pkt(input int len, input int nacc);
    for (int i = 0; i < len; i++) begin
      beat(gdat, i == len - 1, 4'hF, i < nacc);
      gdat++;
    end
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1; rd_addr = 12'(a);
    rd_q.push_back((a < 64) ? mm[a] : 32'd0);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tvalid = 1'b1; tdata = 32'hDEAD_BEEF; tstrb = 4'hF; tlast = 1'b0;
    @(negedge clk);
    chk("tready_during_clear", 32'(tready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; tvalid = 1'b0;
    model_reset();
  endtask

  initial begin
    areset = 1'b1; enable = 1'b0; clear = 1'b0; tdata = '0; tstrb = '0;
    tvalid = 1'b0; tlast = 1'b0; rd_en = 1'b0; rd_addr = '0;

    // reset state
    tick();
    chk_reset("rst0");
    areset = 1'b0;

    // basic 4-beat packet; tready rises one cycle after enable
    enable = 1'b1;
    @(negedge clk);
    chk("tready_before_enable_sampled", 32'(tready), 32'd0);
    @(posedge clk); #1;
    beat(32'h11, 1'b0, 4'hF, 1'b1);
    beat(32'h22, 1'b0, 4'hF, 1'b1);
    beat(32'h33, 1'b0, 4'hF, 1'b1);
    beat(32'h44, 1'b1, 4'hF, 1'b1);
    chk_stat("pkt4", 4, 1, 4, 1'b0, 1'b0, 1'b0);
    rd(2);

    // fill exactly at a packet boundary: 4x16 accepted, then refused
    do_clear();
    send_pkt(16, 16); send_pkt(16, 16); send_pkt(16, 16); send_pkt(16, 16);
    send_pkt(6, 0);
    chk_stat("fill_aligned", 64, 4, 16, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("tready_when_full", 32'(tready), 32'd0);
    @(posedge clk); #1;
    rd(63);

    // fill with a packet still open: trunc set, packet not counted
    do_clear();
    send_pkt(16, 16); send_pkt(16, 16); send_pkt(16, 16); send_pkt(6, 6);
    send_pkt(12, 10);
    chk_stat("fill_trunc", 64, 4, 6, 1'b1, 1'b0, 1'b1);

    // enable dropped mid-packet: packet finishes, then sink idles
    do_clear();
    beat(32'hB1, 1'b0, 4'hF, 1'b1);
    enable = 1'b0;
    beat(32'hB2, 1'b0, 4'hF, 1'b1);
    beat(32'hB3, 1'b0, 4'hF, 1'b1);
    beat(32'hB4, 1'b0, 4'hF, 1'b1);
    beat(32'hB5, 1'b1, 4'hF, 1'b1);
    beat(32'hB6, 1'b1, 4'hF, 1'b0);
    chk_stat("enable_drop", 5, 1, 5, 1'b0, 1'b0, 1'b0);

    // strobe rules, then clear with a beat presented
    do_clear();
    enable = 1'b1;
    beat(32'hA1, 1'b1, 4'h1, 1'b1);
    chk_stat("strb_final_partial", 1, 1, 1, 1'b0, 1'b0, 1'b0);
    beat(32'hA2, 1'b0, 4'h3, 1'b1);
    beat(32'hA3, 1'b1, 4'hF, 1'b1);
    chk_stat("strb_nonfinal", 3, 2, 2, 1'b0, 1'b1, 1'b0);
    do_clear();
    chk_stat("after_clear", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    rd(0);

    // reset mid-packet, then a fresh 2-beat packet with a colliding read
    beat(32'hE1, 1'b0, 4'hF, 1'b1);
    beat(32'hE2, 1'b0, 4'hF, 1'b1);
    beat(32'hE3, 1'b0, 4'hF, 1'b1);
    areset = 1'b1;
    tick();
    chk_reset("rst_mid");
    areset = 1'b0;
    model_reset();
    tick();
    rd_en = 1'b1; rd_addr = 12'd0;
    rd_q.push_back(mm[0]);
    beat(32'hC1, 1'b0, 4'hF, 1'b1);
    beat(32'hC2, 1'b1, 4'hF, 1'b1);
    chk_stat("after_reset_pkt", 2, 1, 2, 1'b0, 1'b0, 1'b0);
    rd(100);
    rd(1);

    tick(); tick();
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("pkt_queue_drained", 32'(pkt_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
